// File: rtl/pool_engine_v2.sv
// Windowed average/max pooling over a signed 8-bit picture fetched row by row.
// Define POOL_RELU_EN to clamp negative results to zero before they are written.
module pool_engine_v2 #(
  parameter int ADDR_WIDTH        = 19,
  parameter int WORD_WIDTH        = 8,
  parameter int NUM_WORDS_IN_LINE = 32,
  parameter int X_ROWS_NUM        = 128,
  parameter int X_COLS_NUM        = 128,
  parameter int Y_ROWS_NUM        = 8,
  parameter int Y_COLS_NUM        = 8,
  parameter int X_LOG2_ROWS_NUM   = $clog2(X_ROWS_NUM),
  parameter int X_LOG2_COLS_NUM   = $clog2(X_COLS_NUM),
  parameter int Y_LOG2_ROWS_NUM   = $clog2(Y_ROWS_NUM),
  parameter int Y_LOG2_COLS_NUM   = $clog2(Y_COLS_NUM),
  parameter int ACC_WIDTH         = WORD_WIDTH + Y_LOG2_ROWS_NUM + Y_LOG2_COLS_NUM
) (
  input  logic                                    clk,
  input  logic                                    rst_n,
  input  logic                                    sw_pool_go,
  input  logic                                    sw_pool_mode,
  input  logic [ADDR_WIDTH-1:0]                   sw_pool_addr_x,
  input  logic [ADDR_WIDTH-1:0]                   sw_pool_addr_z,
  input  logic [X_LOG2_ROWS_NUM:0]                sw_pool_x_m,
  input  logic [X_LOG2_COLS_NUM:0]                sw_pool_x_n,
  input  logic [Y_LOG2_ROWS_NUM:0]                sw_pool_y_m,
  input  logic [Y_LOG2_COLS_NUM:0]                sw_pool_y_n,
  input  logic [Y_LOG2_ROWS_NUM:0]                sw_pool_jump_row,
  input  logic [Y_LOG2_COLS_NUM:0]                sw_pool_jump_col,
  output logic                                    pool_sw_busy_ind,
  output logic                                    sw_pool_done,
  output logic                                    sw_pool_err,
  output logic                                    rd_req,
  output logic [ADDR_WIDTH-1:0]                   rd_start_addr,
  output logic [Y_LOG2_COLS_NUM:0]                rd_size_bytes,
  input  logic                                    rd_valid,
  input  logic [NUM_WORDS_IN_LINE*WORD_WIDTH-1:0] rd_data,
  input  logic [$clog2(NUM_WORDS_IN_LINE)-1:0]    rd_last_valid,
  output logic                                    wr_req,
  output logic [ADDR_WIDTH-1:0]                   wr_addr,
  output logic [WORD_WIDTH-1:0]                   wr_data,
  input  logic                                    wr_ack
);
  localparam int XRW = X_LOG2_ROWS_NUM + 1;
  localparam int XCW = X_LOG2_COLS_NUM + 1;
  localparam int YRW = Y_LOG2_ROWS_NUM + 1;
  localparam int YCW = Y_LOG2_COLS_NUM + 1;
  localparam int LVW = $clog2(NUM_WORDS_IN_LINE);
  localparam logic signed [WORD_WIDTH-1:0] W_MIN = {1'b1, {(WORD_WIDTH-1){1'b0}}};

  // Handshakes: rd_req/wr_req rise registered and stay high until the cycle the
  // memory side strobes rd_valid/wr_ack; address and data are frozen meanwhile.
  typedef enum logic [2:0] {S_IDLE, S_CHECK, S_RD_REQ, S_RD_WAIT, S_RESULT, S_WR, S_DONE} state_t;
  state_t state;

  logic                         mode_q;
  logic [ADDR_WIDTH-1:0]        addr_x_q, addr_z_q, wr_idx;
  logic [XRW-1:0]               x_m_q, row_pos;
  logic [XCW-1:0]               x_n_q, col_pos;
  logic [YRW-1:0]               y_m_q, jr_q, r_cnt;
  logic [YCW-1:0]               y_n_q, jc_q;
  logic signed [ACC_WIDTH-1:0]  acc, row_sum, avg_full;
  logic signed [WORD_WIDTH-1:0] mx, row_max, fold_b;
  logic [WORD_WIDTH-1:0]        res;
  logic [3:0]                   shamt;
  logic [ADDR_WIDTH-1:0]        rd_addr_nxt;
  logic [XCW:0]                 col_end_nxt;
  logic [XRW:0]                 row_end_nxt;
  logic                         cfg_bad;

  function automatic logic is_pow2(input logic [7:0] v);
    return (v != 8'd0) && ((v & (v - 8'd1)) == 8'd0);
  endfunction

  function automatic logic [3:0] log2_of(input logic [7:0] v);
    logic [3:0] l;
    l = '0;
    for (int i = 0; i < 8; i++)
      if (v[i]) l = 4'(i);
    return l;
  endfunction

  generate
    if (Y_COLS_NUM < NUM_WORDS_IN_LINE) begin : g_unused
      logic unused_rd_bits;
      assign unused_rd_bits = ^rd_data[NUM_WORDS_IN_LINE*WORD_WIDTH-1:Y_COLS_NUM*WORD_WIDTH];
    end
  endgenerate

  // Fold the first y_n bytes of the beat; anything beyond the window is ignored.
  always_comb begin
    row_sum = '0;
    row_max = W_MIN;
    fold_b  = '0;
    for (int j = 0; j < Y_COLS_NUM; j++) begin
      fold_b = $signed(rd_data[j*WORD_WIDTH +: WORD_WIDTH]);
      if (YCW'(j) < y_n_q) begin
        row_sum = row_sum + {{(ACC_WIDTH-WORD_WIDTH){fold_b[WORD_WIDTH-1]}}, fold_b};
        if (fold_b > row_max) row_max = fold_b;
      end
    end
  end

  always_comb begin
    shamt    = log2_of(8'(y_m_q)) + log2_of(8'(y_n_q));
    avg_full = acc >>> shamt;
    res      = mode_q ? mx : avg_full[WORD_WIDTH-1:0];
`ifdef POOL_RELU_EN
    if (res[WORD_WIDTH-1]) res = '0;
`else
    res = res;
`endif
  end

  assign rd_addr_nxt = addr_x_q + (ADDR_WIDTH'(row_pos) + ADDR_WIDTH'(r_cnt)) * ADDR_WIDTH'(x_n_q)
                     + ADDR_WIDTH'(col_pos);
  assign col_end_nxt = (XCW+1)'(col_pos) + (XCW+1)'(jc_q) + (XCW+1)'(y_n_q);
  assign row_end_nxt = (XRW+1)'(row_pos) + (XRW+1)'(jr_q) + (XRW+1)'(y_m_q);
  assign cfg_bad = !is_pow2(8'(y_m_q)) || !is_pow2(8'(y_n_q)) ||
                   (XRW'(y_m_q) > x_m_q) || (XCW'(y_n_q) > x_n_q) ||
                   (jr_q == '0) || (jc_q == '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state            <= S_IDLE;
      mode_q           <= 1'b0;
      addr_x_q         <= '0;
      addr_z_q         <= '0;
      x_m_q            <= '0;
      x_n_q            <= '0;
      y_m_q            <= '0;
      y_n_q            <= '0;
      jr_q             <= '0;
      jc_q             <= '0;
      row_pos          <= '0;
      col_pos          <= '0;
      r_cnt            <= '0;
      wr_idx           <= '0;
      acc              <= '0;
      mx               <= '0;
      pool_sw_busy_ind <= 1'b0;
      sw_pool_done     <= 1'b0;
      sw_pool_err      <= 1'b0;
      rd_req           <= 1'b0;
      rd_start_addr    <= '0;
      rd_size_bytes    <= '0;
      wr_req           <= 1'b0;
      wr_addr          <= '0;
      wr_data          <= '0;
    end else begin
      case (state)
        S_IDLE: if (sw_pool_go) begin
          mode_q           <= sw_pool_mode;
          addr_x_q         <= sw_pool_addr_x;
          addr_z_q         <= sw_pool_addr_z;
          x_m_q            <= sw_pool_x_m;
          x_n_q            <= sw_pool_x_n;
          y_m_q            <= sw_pool_y_m;
          y_n_q            <= sw_pool_y_n;
          jr_q             <= sw_pool_jump_row;
          jc_q             <= sw_pool_jump_col;
          pool_sw_busy_ind <= 1'b1;
          sw_pool_err      <= 1'b0;
          state            <= S_CHECK;
        end
        S_CHECK: begin
          row_pos <= '0;
          col_pos <= '0;
          r_cnt   <= '0;
          wr_idx  <= '0;
          acc     <= '0;
          mx      <= W_MIN;
          if (cfg_bad) begin
            sw_pool_err      <= 1'b1;
            pool_sw_busy_ind <= 1'b0;
            sw_pool_done     <= 1'b1;
            state            <= S_DONE;
          end else begin
            state <= S_RD_REQ;
          end
        end
        S_RD_REQ: begin
          rd_req        <= 1'b1;
          rd_start_addr <= rd_addr_nxt;
          rd_size_bytes <= y_n_q;
          state         <= S_RD_WAIT;
        end
        S_RD_WAIT: if (rd_valid) begin
          rd_req <= 1'b0;
          acc    <= acc + row_sum;
          if (row_max > mx) mx <= row_max;
          if (rd_last_valid != LVW'(y_n_q - 1'b1)) sw_pool_err <= 1'b1;
          if (r_cnt == y_m_q - 1'b1) begin
            r_cnt <= '0;
            state <= S_RESULT;
          end else begin
            r_cnt <= r_cnt + 1'b1;
            state <= S_RD_REQ;
          end
        end
        S_RESULT: begin
          wr_req  <= 1'b1;
          wr_addr <= addr_z_q + wr_idx;
          wr_data <= res;
          state   <= S_WR;
        end
        S_WR: if (wr_ack) begin
          wr_req <= 1'b0;
          wr_idx <= wr_idx + 1'b1;
          acc    <= '0;
          mx     <= W_MIN;
          // Next window fits in this output row if its right edge stays inside x_n.
          if (col_end_nxt <= {1'b0, x_n_q}) begin
            col_pos <= col_pos + XCW'(jc_q);
            state   <= S_RD_REQ;
          end else begin
            col_pos <= '0;
            if (row_end_nxt <= {1'b0, x_m_q}) begin
              row_pos <= row_pos + XRW'(jr_q);
              state   <= S_RD_REQ;
            end else begin
              pool_sw_busy_ind <= 1'b0;
              sw_pool_done     <= 1'b1;
              state            <= S_DONE;
            end
          end
        end
        S_DONE: begin
          sw_pool_done <= 1'b0;
          state        <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_pool_engine_v2.sv
// Directed bench for pool_engine_v2: memory responders, a window-level reference
// model feeding expected queues, one compare process, and literal spot checks.
module tb_pool_engine_v2;
  localparam int AW = 19;
  localparam int WW = 8;
  localparam int NW = 32;
  localparam logic [AW-1:0] AX = 19'h100;
  localparam logic [AW-1:0] AZ = 19'h300;

  logic          clk, rst_n;
  logic          sw_pool_go, sw_pool_mode;
  logic [AW-1:0] sw_pool_addr_x, sw_pool_addr_z;
  logic [7:0]    sw_pool_x_m, sw_pool_x_n;
  logic [3:0]    sw_pool_y_m, sw_pool_y_n, sw_pool_jump_row, sw_pool_jump_col;
  logic          pool_sw_busy_ind, sw_pool_done, sw_pool_err;
  logic          rd_req, rd_valid, wr_req, wr_ack;
  logic [AW-1:0] rd_start_addr, wr_addr;
  logic [3:0]    rd_size_bytes;
  logic [NW*WW-1:0] rd_data;
  logic [4:0]    rd_last_valid;
  logic [WW-1:0] wr_data;

  pool_engine_v2 dut (
    .clk(clk), .rst_n(rst_n), .sw_pool_go(sw_pool_go), .sw_pool_mode(sw_pool_mode),
    .sw_pool_addr_x(sw_pool_addr_x), .sw_pool_addr_z(sw_pool_addr_z),
    .sw_pool_x_m(sw_pool_x_m), .sw_pool_x_n(sw_pool_x_n),
    .sw_pool_y_m(sw_pool_y_m), .sw_pool_y_n(sw_pool_y_n),
    .sw_pool_jump_row(sw_pool_jump_row), .sw_pool_jump_col(sw_pool_jump_col),
    .pool_sw_busy_ind(pool_sw_busy_ind), .sw_pool_done(sw_pool_done), .sw_pool_err(sw_pool_err),
    .rd_req(rd_req), .rd_start_addr(rd_start_addr), .rd_size_bytes(rd_size_bytes),
    .rd_valid(rd_valid), .rd_data(rd_data), .rd_last_valid(rd_last_valid),
    .wr_req(wr_req), .wr_addr(wr_addr), .wr_data(wr_data), .wr_ack(wr_ack)
  );

  logic [7:0]       mem [0:1023];
  logic [AW+WW-1:0] exp_q[$];
  logic [AW+3:0]    exp_rd_q[$];
  logic [7:0]       got_wr[$];
  int n_checks = 0, n_fail = 0, done_seen = 0;
  int rd_lat = 0, wr_lat = 0;
  bit bad_lv = 0;

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail + 1);
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input longint act, input longint exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // reference model: enumerate output windows in raster order
  task automatic build_model(input bit mode, input int xm, xn, ym, yn, jr, jc);
    int sh, sum, mxv, v, a, res, idx;
    sh = 0;
    while ((1 << sh) < ym) sh++;
    for (int k = 0; (1 << k) < yn; k++) sh++;
    idx = 0;
    for (int orow = 0; orow * jr + ym <= xm; orow++) begin
      for (int ocol = 0; ocol * jc + yn <= xn; ocol++) begin
        sum = 0;
        mxv = -128;
        for (int rr = 0; rr < ym; rr++) begin
          a = int'(AX) + (orow * jr + rr) * xn + ocol * jc;
          exp_rd_q.push_back({AW'(a), 4'(yn)});
          for (int cc = 0; cc < yn; cc++) begin
            v = $signed(mem[(a + cc) & 1023]);
            sum += v;
            if (v > mxv) mxv = v;
          end
        end
        res = mode ? mxv : (sum >>> sh);
`ifdef POOL_RELU_EN
        if (res < 0) res = 0;
`endif
        exp_q.push_back({AW'(int'(AZ) + idx), 8'(res)});
        idx++;
      end
    end
  endtask

  // read responder
  initial begin
    int cnt;
    cnt = 0;
    rd_valid = 1'b0;
    rd_data = '0;
    rd_last_valid = '0;
    forever begin
      @(negedge clk);
      if (rd_valid) begin
        rd_valid = 1'b0;
        cnt = 0;
      end else if (rd_req && rst_n) begin
        if (cnt >= rd_lat) begin
          for (int j = 0; j < NW; j++)
            rd_data[j*8 +: 8] = (j < int'(rd_size_bytes)) ? mem[(int'(rd_start_addr) + j) & 1023]
                                                          : 8'($urandom);
          rd_last_valid = bad_lv ? 5'(rd_size_bytes) : 5'(rd_size_bytes - 4'd1);
          rd_valid = 1'b1;
          cnt = 0;
        end else cnt++;
      end else cnt = 0;
    end
  end

  // write responder
  initial begin
    int cnt;
    cnt = 0;
    wr_ack = 1'b0;
    forever begin
      @(negedge clk);
      if (wr_ack) begin
        wr_ack = 1'b0;
        cnt = 0;
      end else if (wr_req && rst_n) begin
        if (cnt >= wr_lat) begin
          wr_ack = 1'b1;
          cnt = 0;
        end else cnt++;
      end else cnt = 0;
    end
  end

  // compare process: handshakes against the model, held requests must stay frozen
  initial begin
    bit rd_pend, wr_pend;
    logic [AW+3:0]    rd_hold;
    logic [AW+WW-1:0] wr_hold;
    rd_pend = 0;
    wr_pend = 0;
    rd_hold = '0;
    wr_hold = '0;
    forever begin
      @(negedge clk);
      #2;
      if (!rst_n) begin
        rd_pend = 0;
        wr_pend = 0;
      end else begin
        if (sw_pool_done) done_seen++;
        if (rd_req && rd_pend) chk("rd_req_stable", {rd_start_addr, rd_size_bytes}, rd_hold);
        if (rd_req && rd_valid) begin
          if (exp_rd_q.size() == 0) chk("extra_read", 1, 0);
          else chk("rd_addr_size", {rd_start_addr, rd_size_bytes}, exp_rd_q.pop_front());
        end
        rd_pend = rd_req && !rd_valid;
        rd_hold = {rd_start_addr, rd_size_bytes};
        if (wr_req && wr_pend) chk("wr_req_stable", {wr_addr, wr_data}, wr_hold);
        if (wr_req && wr_ack) begin
          got_wr.push_back(wr_data);
          if (exp_q.size() == 0) chk("extra_write", 1, 0);
          else chk("wr_addr_data", {wr_addr, wr_data}, exp_q.pop_front());
        end
        wr_pend = wr_req && !wr_ack;
        wr_hold = {wr_addr, wr_data};
      end
    end
  end

  // driver: launch a job with a one-cycle go and wait (bounded) for done
  task automatic run_job(input string tag, input bit mode, input int xm, xn, ym, yn, jr, jc,
                         input bit build, input bit exp_err, output int cyc);
    exp_q.delete();
    exp_rd_q.delete();
    got_wr.delete();
    if (build) build_model(mode, xm, xn, ym, yn, jr, jc);
    @(negedge clk);
    sw_pool_mode = mode;
    sw_pool_addr_x = AX;
    sw_pool_addr_z = AZ;
    sw_pool_x_m = 8'(xm);
    sw_pool_x_n = 8'(xn);
    sw_pool_y_m = 4'(ym);
    sw_pool_y_n = 4'(yn);
    sw_pool_jump_row = 4'(jr);
    sw_pool_jump_col = 4'(jc);
    sw_pool_go = 1'b1;
    @(negedge clk);
    #1;
    sw_pool_go = 1'b0;
    chk({tag, "_busy_set"}, pool_sw_busy_ind, 1);
    cyc = 1;
    while (!sw_pool_done && cyc < 20000) begin
      @(negedge clk);
      #1;
      cyc++;
    end
    if (!sw_pool_done) chk({tag, "_done_timeout"}, 0, 1);
    else begin
      chk({tag, "_busy_at_done"}, pool_sw_busy_ind, 0);
      chk({tag, "_err"}, sw_pool_err, exp_err);
    end
    @(negedge clk);
    #3;
    chk({tag, "_done_pulse_1cyc"}, sw_pool_done, 0);
    chk({tag, "_writes_left"}, exp_q.size(), 0);
    chk({tag, "_reads_left"}, exp_rd_q.size(), 0);
  endtask

  task automatic chk_wr4(input string tag, input logic [7:0] a, b, c, d);
    chk({tag, "_nwr"}, got_wr.size(), 4);
    if (got_wr.size() == 4) begin
      chk({tag, "_w0"}, got_wr[0], a);
      chk({tag, "_w1"}, got_wr[1], b);
      chk({tag, "_w2"}, got_wr[2], c);
      chk({tag, "_w3"}, got_wr[3], d);
    end
  endtask

  task automatic fill_ramp;
    for (int i = 0; i < 16; i++) mem[int'(AX) + i] = 8'(i);
  endtask

  initial begin
    int cyc, ds;
    logic [7:0] neg_exp, min_exp;
    for (int i = 0; i < 1024; i++) mem[i] = 8'(i * 13 + 5);
    rst_n = 1'b0;
    sw_pool_go = 1'b0;
    sw_pool_mode = 1'b0;
    sw_pool_addr_x = '0;
    sw_pool_addr_z = '0;
    sw_pool_x_m = '0;
    sw_pool_x_n = '0;
    sw_pool_y_m = '0;
    sw_pool_y_n = '0;
    sw_pool_jump_row = '0;
    sw_pool_jump_col = '0;
    repeat (3) @(negedge clk);
    #1;
    chk("reset_outputs", {pool_sw_busy_ind, sw_pool_done, sw_pool_err, rd_req, rd_start_addr,
                          rd_size_bytes, wr_req, wr_addr, wr_data}, 0);
    rst_n = 1'b1;

    fill_ramp();
    run_job("avg2x2", 0, 4, 4, 2, 2, 2, 2, 1, 0, cyc);
    chk_wr4("avg2x2", 8'd2, 8'd4, 8'd10, 8'd12);
    run_job("max2x2", 1, 4, 4, 2, 2, 2, 2, 1, 0, cyc);
    chk_wr4("max2x2", 8'd5, 8'd7, 8'd13, 8'd15);

    run_job("stride1", 0, 4, 4, 2, 2, 1, 1, 1, 0, cyc);
    chk("stride1_nwr", got_wr.size(), 9);
    if (got_wr.size() == 9) begin
      chk("stride1_first", got_wr[0], 8'd2);
      chk("stride1_last", got_wr[8], 8'd12);
    end

    rd_lat = 7;
    wr_lat = 5;
    run_job("slow_mem", 0, 4, 4, 2, 2, 2, 2, 1, 0, cyc);
    chk_wr4("slow_mem", 8'd2, 8'd4, 8'd10, 8'd12);
    rd_lat = 0;
    wr_lat = 0;

    bad_lv = 1;
    run_job("bad_last_valid", 1, 4, 4, 2, 2, 2, 2, 1, 1, cyc);
    chk_wr4("bad_last_valid", 8'd5, 8'd7, 8'd13, 8'd15);
    bad_lv = 0;

    mem[int'(AX) + 0] = 8'hFF;
    mem[int'(AX) + 1] = 8'hFE;
    mem[int'(AX) + 2] = 8'hFE;
    mem[int'(AX) + 3] = 8'hFE;
`ifdef POOL_RELU_EN
    neg_exp = 8'h00;
    min_exp = 8'h00;
`else
    neg_exp = 8'hFE;
    min_exp = 8'h80;
`endif
    run_job("neg_avg", 0, 2, 2, 2, 2, 1, 1, 1, 0, cyc);
    chk("neg_avg_nwr", got_wr.size(), 1);
    if (got_wr.size() == 1) chk("neg_avg_floor", got_wr[0], neg_exp);

    run_job("bad_yn3", 0, 4, 4, 2, 3, 1, 1, 0, 1, cyc);
    chk("bad_yn3_done_within_3", (cyc <= 3), 1);
    chk("bad_yn3_no_writes", got_wr.size(), 0);

    for (int i = 0; i < 80; i++) mem[int'(AX) + i] = 8'(i * 37 + 11);
    rd_lat = 2;
    wr_lat = 1;
    run_job("rect_avg", 0, 8, 10, 4, 2, 3, 2, 1, 0, cyc);
    chk("rect_avg_nwr", got_wr.size(), 10);
    run_job("rect_max", 1, 8, 10, 4, 2, 3, 2, 1, 0, cyc);
    rd_lat = 0;
    wr_lat = 0;

    for (int i = 0; i < 64; i++) mem[int'(AX) + i] = 8'h80;
    run_job("full8x8_min", 0, 8, 8, 8, 8, 1, 1, 1, 0, cyc);
    if (got_wr.size() == 1) chk("full8x8_min_val", got_wr[0], min_exp);
    else chk("full8x8_min_nwr", got_wr.size(), 1);
    for (int i = 0; i < 64; i++) mem[int'(AX) + i] = 8'h7F;
    run_job("full8x8_max", 1, 8, 8, 8, 8, 1, 1, 1, 0, cyc);
    if (got_wr.size() == 1) chk("full8x8_max_val", got_wr[0], 8'h7F);
    else chk("full8x8_max_nwr", got_wr.size(), 1);

    // reset while a read is outstanding
    fill_ramp();
    rd_lat = 7;
    @(negedge clk);
    sw_pool_mode = 1'b0;
    sw_pool_x_m = 8'd4;
    sw_pool_x_n = 8'd4;
    sw_pool_y_m = 4'd2;
    sw_pool_y_n = 4'd2;
    sw_pool_jump_row = 4'd2;
    sw_pool_jump_col = 4'd2;
    sw_pool_go = 1'b1;
    @(negedge clk);
    sw_pool_go = 1'b0;
    cyc = 0;
    while (!rd_req && cyc < 50) begin
      @(negedge clk);
      cyc++;
    end
    chk("rst_job_rd_req_seen", rd_req, 1);
    repeat (2) @(negedge clk);
    ds = done_seen;
    rst_n = 1'b0;
    #1;
    chk("midjob_reset_outputs", {pool_sw_busy_ind, sw_pool_done, sw_pool_err, rd_req,
                                 rd_start_addr, rd_size_bytes, wr_req, wr_addr, wr_data}, 0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    #3;
    chk("midjob_reset_no_done", done_seen, ds);
    rd_lat = 0;
    run_job("after_reset", 0, 4, 4, 2, 2, 2, 2, 1, 0, cyc);
    chk_wr4("after_reset", 8'd2, 8'd4, 8'd10, 8'd12);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/pool_engine_v2.md
Name: pool_engine_v2

Overview:
- Parametrised successor to the fixed-mode pooling unit.
- Fetches each Y_M x Y_N window of a signed 8-bit picture row by row over a line-based read port, reduces it with average or max, and writes one byte per window over a write port.
- Programmable stride in rows and columns, and programmable window size up to the compile-time maximum.
- Sits between the SW register block and the memory arbiter, alongside the conv/fc accelerators.

Parameters:
- ADDR_WIDTH, 19, memory byte-address width.
- WORD_WIDTH, 8, element width in bits; signed two's complement.
- NUM_WORDS_IN_LINE, 32, elements per read beat.
- X_ROWS_NUM, 128, maximum picture rows.
- X_COLS_NUM, 128, maximum picture columns.
- Y_ROWS_NUM, 8, maximum window rows.
- Y_COLS_NUM, 8, maximum window columns; must be <= NUM_WORDS_IN_LINE.
- X_LOG2_ROWS_NUM, $clog2(X_ROWS_NUM), picture row-count width minus one.
- X_LOG2_COLS_NUM, $clog2(X_COLS_NUM), picture column-count width minus one.
- Y_LOG2_ROWS_NUM, $clog2(Y_ROWS_NUM), window row-count width minus one.
- Y_LOG2_COLS_NUM, $clog2(Y_COLS_NUM), window column-count width minus one.
- ACC_WIDTH, WORD_WIDTH+Y_LOG2_ROWS_NUM+Y_LOG2_COLS_NUM, signed accumulator width.

Ports:
- clk  in  1  single clock for the whole block.
- rst_n  in  1  asynchronous, active-low reset.
- sw_pool_go  in  1  level start request; sampled only in IDLE.
- sw_pool_mode  in  1  0 = average, 1 = max.
- sw_pool_addr_x  in  ADDR_WIDTH  picture base address.
- sw_pool_addr_z  in  ADDR_WIDTH  result base address.
- sw_pool_x_m  in  X_LOG2_ROWS_NUM+1  picture rows.
- sw_pool_x_n  in  X_LOG2_COLS_NUM+1  picture columns.
- sw_pool_y_m  in  Y_LOG2_ROWS_NUM+1  window rows; power of two.
- sw_pool_y_n  in  Y_LOG2_COLS_NUM+1  window columns; power of two.
- sw_pool_jump_row  in  Y_LOG2_ROWS_NUM+1  row stride, >= 1.
- sw_pool_jump_col  in  Y_LOG2_COLS_NUM+1  column stride, >= 1.
- pool_sw_busy_ind  out  1  high from go acceptance until done.
- sw_pool_done  out  1  one-cycle pulse when the job ends.
- sw_pool_err  out  1  sticky illegal-configuration flag; cleared on next accepted go.
- rd_req  out  1  read request; held until rd_valid.
- rd_start_addr  out  ADDR_WIDTH  first byte of the window row.
- rd_size_bytes  out  Y_LOG2_COLS_NUM+1  equals y_n.
- rd_valid  in  1  one-cycle data strobe.
- rd_data  in  NUM_WORDS_IN_LINE*WORD_WIDTH  byte j at bits [8j+7:8j] = address start+j.
- rd_last_valid  in  $clog2(NUM_WORDS_IN_LINE)  index of last valid byte.
- wr_req  out  1  write request; held until wr_ack.
- wr_addr  out  ADDR_WIDTH  result address.
- wr_data  out  WORD_WIDTH  result byte.
- wr_ack  in  1  write accepted.

Behaviour:
- Reset: all outputs 0; FSM to IDLE; counters and accumulator 0. Reset mid-job aborts immediately with no done pulse; pending requests drop in the cycle reset asserts.
- FSM: IDLE -> CHECK -> RD_REQ -> RD_WAIT -> (next row ? RD_REQ : RESULT) -> WR -> (more windows ? RD_REQ : DONE) -> IDLE.
- IDLE: on go=1, latch all sw_* inputs, set busy, clear err.
- CHECK: illegal if y_m or y_n is 0 or not a power of two, y_m>x_m, y_n>x_n, or a jump is 0.
  - Illegal: set err, go to DONE; no memory traffic.
- Output dimensions: out_rows=(x_m-y_m)/jump_row+1, out_cols=(x_n-y_n)/jump_col+1. Counters orow, ocol, r.
- RD_REQ: rd_req=1, rd_start_addr=addr_x+(orow*jump_row+r)*x_n+ocol*jump_col, rd_size_bytes=y_n.
- RD_WAIT:
  - rd_req stays high until the rd_valid cycle, then drops.
  - On rd_valid, fold bytes 0..y_n-1; bytes above y_n-1 are ignored.
  - rd_last_valid != y_n-1 sets err; processing continues.
- Accumulator:
  - Avg: signed sum in ACC_WIDTH, no overflow by construction.
  - Max: running signed max, initialised to -128 at window start.
- RESULT (1 cycle):
  - Avg = sum >>> (log2 y_m + log2 y_n), floor rounding, truncated to 8 bits.
  - Max = running max.
- WR:
  - wr_req=1, wr_addr=addr_z+orow*out_cols+ocol, wr_data stable until the wr_ack cycle.
  - Then advance ocol; wrap to 0 and advance orow.
- DONE: sw_pool_done pulses 1 cycle; busy drops the same cycle; next cycle IDLE.
- go held high after done restarts a new job from IDLE. go while busy is ignored.
- rd_valid outside RD_WAIT and wr_ack outside WR are ignored.
- Latency per window: y_m*(1+read latency)+1+(1+write latency) cycles minimum.

Optional Feature:
- Macro: POOL_RELU_EN.
- Defined: results < 0 are written as 0 in both modes.
- Undefined: signed results are written unchanged.

Test Plan:
- 4x4 picture 0..15, 2x2 window, stride 2, avg -> wr_data 2,4,10,12 at addr_z+0..3; then done pulse, busy=0.
- Same picture, max mode -> 5,7,13,15.
- 2x2 window {-1,-2,-2,-2}, avg -> 0xFE (-2, floor); with POOL_RELU_EN -> 0x00.
- 4x4 picture, 2x2 window, stride 1 -> 9 writes; first read at addr_x+0, sizes 2; write addrs z..z+8.
- wr_ack delayed 5 cycles and rd_valid delayed 7 cycles -> wr_req/wr_addr/wr_data stable throughout; no extra reads or writes.
- y_n=3 -> err=1, done within 3 cycles, no rd_req. Separately, rst_n low during RD_WAIT -> all outputs 0, no done; new go runs cleanly.
